instr_fetch_queue: RTL and testbench

Instruction fetch stage directly upstream of the control unit. It reads instruction words from the instruction memory through a one-cycle-latency read port and prefetches them into a small FIFO. It presents them one at a time with a valid/ready handshake, together with the program counter of the presented word. Fetch stops at a HALT opcode and resumes at a new address on a flush.

---
 rtl/instr_fetch_queue_if.sv | 25 ++
 rtl/instr_fetch_queue.sv | 124 ++++++++++++
 tb/tb_instr_fetch_queue.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_queue_if.sv
// Bundles the instruction-memory read port and the instruction handshake
// between the fetch queue (master) and its environment (slave).
interface instr_fetch_queue_if #(
    parameter int unsigned INSTRUCTION_SIZE = 29,
    parameter int unsigned IM_ADDR_WIDTH    = 32
);
    logic                        im_rden;
    logic [IM_ADDR_WIDTH-1:0]    im_rdaddr;
    logic [INSTRUCTION_SIZE-1:0] im_rddata;
    logic [INSTRUCTION_SIZE-1:0] instruction;
    logic                        instr_valid;
    logic                        instr_ready;
    logic [IM_ADDR_WIDTH-1:0]    pc;
    logic                        halted;

    modport master (
        output im_rden, im_rdaddr, instruction, instr_valid, pc, halted,
        input  im_rddata, instr_ready
    );

    modport slave (
        input  im_rden, im_rdaddr, instruction, instr_valid, pc, halted,
        output im_rddata, instr_ready
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction prefetch queue: issues one-cycle-latency memory reads, buffers the
// returned words with their addresses, and presents them show-ahead until a HALT.
module instr_fetch_queue #(
    parameter int unsigned INSTRUCTION_SIZE = 29,
    parameter int unsigned IM_ADDR_WIDTH    = 32,
    parameter int unsigned FIFO_DEPTH       = 4,
    parameter int unsigned OPCODE_WIDTH     = 3,
    parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE = 3'b111
) (
    input  logic                     CLK,
    input  logic                     SYNC_RST,
    input  logic                     EN,
    input  logic                     flush,
    input  logic [IM_ADDR_WIDTH-1:0] flush_addr,
    instr_fetch_queue_if.master      bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 2;

    logic [INSTRUCTION_SIZE-1:0] mem_data [FIFO_DEPTH];
    logic [IM_ADDR_WIDTH-1:0]    mem_addr [FIFO_DEPTH];

    logic [IM_ADDR_WIDTH-1:0] fa;
    logic [IM_ADDR_WIDTH-1:0] cap_addr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [PTR_W-1:0]         wr_ptr;
    logic [CNT_W-1:0]         count;
    logic                     cap_pending;
    logic                     halt_seen;

    logic                        pop_c;
    logic                        cap_halt_c;
    logic                        wr_c;
    logic                        issue_c;
    logic [OCC_W-1:0]            occ_c;
    logic [PTR_W-1:0]            rd_ptr_n;
    logic [CNT_W-1:0]            kept_c;
    logic [CNT_W-1:0]            count_n;
    logic [INSTRUCTION_SIZE-1:0] head_data_c;
    logic [IM_ADDR_WIDTH-1:0]    head_addr_c;
    logic                        head_halt_c;

    // Occupancy counts queued entries, the word arriving now and the read at
    // the memory, so a full pipe of outstanding reads can never overflow.
    always_comb begin
        pop_c       = bus.instr_valid && bus.instr_ready;
        cap_halt_c  = (bus.im_rddata[INSTRUCTION_SIZE-1 -: OPCODE_WIDTH] == HALT_OPCODE);
        wr_c        = cap_pending && !halt_seen;
        occ_c       = OCC_W'(count) + OCC_W'(cap_pending) + OCC_W'(bus.im_rden);
        issue_c     = EN && !halt_seen && !(cap_pending && cap_halt_c)
                      && (occ_c < (OCC_W'(FIFO_DEPTH) + OCC_W'(pop_c)));
        rd_ptr_n    = rd_ptr + PTR_W'(pop_c);
        kept_c      = count - CNT_W'(pop_c);
        count_n     = kept_c + CNT_W'(wr_c);
        head_data_c = mem_data[rd_ptr_n];
        head_addr_c = mem_addr[rd_ptr_n];
        if (kept_c == '0) begin
            head_data_c = bus.im_rddata;
            head_addr_c = cap_addr;
        end
        head_halt_c = (head_data_c[INSTRUCTION_SIZE-1 -: OPCODE_WIDTH] == HALT_OPCODE);
    end

    // Control state and registered outputs; flush overrides pop and capture.
    always_ff @(posedge CLK) begin
        if (SYNC_RST) begin
            fa              <= '0;
            cap_addr        <= '0;
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            count           <= '0;
            cap_pending     <= 1'b0;
            halt_seen       <= 1'b0;
            bus.im_rden     <= 1'b0;
            bus.im_rdaddr   <= '0;
            bus.instruction <= '0;
            bus.instr_valid <= 1'b0;
            bus.pc          <= '0;
            bus.halted      <= 1'b0;
        end else if (flush) begin
            fa              <= flush_addr;
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            count           <= '0;
            cap_pending     <= 1'b0;
            halt_seen       <= 1'b0;
            bus.im_rden     <= 1'b0;
            bus.instr_valid <= 1'b0;
            bus.halted      <= 1'b0;
        end else begin
            bus.im_rden <= issue_c;
            if (issue_c) begin
                bus.im_rdaddr <= fa;
                fa            <= fa + IM_ADDR_WIDTH'(1);
            end
            cap_pending <= bus.im_rden;
            cap_addr    <= bus.im_rdaddr;
            if (wr_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                if (cap_halt_c) begin
                    halt_seen <= 1'b1;
                end
            end
            rd_ptr <= rd_ptr_n;
            count  <= count_n;
            // An empty queue keeps showing the last head.
            if (count_n != '0) begin
                bus.instruction <= head_data_c;
                bus.pc          <= head_addr_c;
            end
            bus.instr_valid <= (count_n != '0) && !head_halt_c;
            bus.halted      <= (count_n != '0) && head_halt_c;
        end
    end

    // Entry storage; stale slots are unreachable once the pointers reset.
    always_ff @(posedge CLK) begin
        if (wr_c) begin
            mem_data[wr_ptr] <= bus.im_rddata;
            mem_addr[wr_ptr] <= cap_addr;
        end
    end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: a memory model, a stream-level reference
// (expected pc/word sequence, issue addresses, occupancy) and directed phases.
module tb_instr_fetch_queue;
    localparam int unsigned IW    = 29;
    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          flush;
    logic [AW-1:0] flush_addr;
    logic          halt_en;
    logic [AW-1:0] halt_addr;

    int n_tests = 0;
    int n_fail  = 0;

    instr_fetch_queue_if #(.INSTRUCTION_SIZE(IW), .IM_ADDR_WIDTH(AW)) bus ();

    instr_fetch_queue #(
        .INSTRUCTION_SIZE(IW), .IM_ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH),
        .OPCODE_WIDTH(3), .HALT_OPCODE(3'b111)
    ) dut (
        .CLK(clk), .SYNC_RST(rst), .EN(en), .flush(flush),
        .flush_addr(flush_addr), .bus(bus)
    );

    always #5 clk = ~clk;

    // Memory contents: word k = k + 0x100, optionally a HALT at halt_addr.
    function automatic logic [IW-1:0] word(input logic [AW-1:0] a);
        logic [AW-1:0] s;
        if (halt_en && a == halt_addr) return {3'b111, 26'(a)};
        s = a + 32'h100;
        return IW'(s);
    endfunction

    always @(posedge clk) begin
        if (bus.im_rden) bus.im_rddata <= word(bus.im_rdaddr);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stream reference: delivered words must follow consecutive addresses from the
    // last restart point, reads must be issued in order, outstanding work bounded.
    logic [AW-1:0] exp_pc    = '0;
    logic [AW-1:0] exp_issue = '0;
    int            issued    = 0;
    int            popped    = 0;

    always @(negedge clk) begin
        if (bus.im_rden) begin
            check("issue_addr", 64'(bus.im_rdaddr), 64'(exp_issue));
            exp_issue = exp_issue + 1;
            issued++;
        end
        if (bus.instr_valid) begin
            check("model_pc", 64'(bus.pc), 64'(exp_pc));
            check("model_instr", 64'(bus.instruction), 64'(word(exp_pc)));
            check("model_not_halted", 64'(bus.halted), 64'd0);
        end
        if (bus.halted) begin
            check("model_halt_pc", 64'(bus.pc), 64'(exp_pc));
            check("model_halt_word", 64'(bus.instruction), 64'(word(exp_pc)));
            check("model_halt_no_issue", 64'(bus.im_rden), 64'd0);
        end
        check("model_occupancy", 64'(issued - popped <= int'(DEPTH)), 64'd1);
        if (rst) begin
            exp_pc = '0; exp_issue = '0; issued = 0; popped = 0;
        end else if (flush) begin
            exp_pc = flush_addr; exp_issue = flush_addr; issued = 0; popped = 0;
        end else if (bus.instr_valid && bus.instr_ready) begin
            exp_pc = exp_pc + 1;
            popped++;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rden"},   64'(bus.im_rden),     64'd0);
        check({tag, "_rdaddr"}, 64'(bus.im_rdaddr),   64'd0);
        check({tag, "_instr"},  64'(bus.instruction), 64'd0);
        check({tag, "_valid"},  64'(bus.instr_valid), 64'd0);
        check({tag, "_pc"},     64'(bus.pc),          64'd0);
        check({tag, "_halted"}, 64'(bus.halted),      64'd0);
    endtask

    logic [AW-1:0] wrap_pc    [4];
    logic [IW-1:0] wrap_instr [4];

    initial begin
        rst = 1'b1; en = 1'b0; flush = 1'b0; flush_addr = '0;
        halt_en = 1'b0; halt_addr = '0; bus.instr_ready = 1'b0;
        wrap_pc    = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
        wrap_instr = '{29'h0FE, 29'h0FF, 29'h100, 29'h101};
        repeat (3) tick();
        check_reset_outputs("reset");

        // First fetch latency and steady stream.
        rst = 1'b0; en = 1'b1; bus.instr_ready = 1'b1;
        tick();
        check("first_rden", 64'(bus.im_rden), 64'd1);
        check("first_rdaddr", 64'(bus.im_rdaddr), 64'd0);
        tick();
        check("latency_valid_low", 64'(bus.instr_valid), 64'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("stream_valid", 64'(bus.instr_valid), 64'd1);
            check("stream_pc", 64'(bus.pc), 64'(k));
            check("stream_instr", 64'(bus.instruction), 64'(32'h100 + k));
        end

        // Back-pressure from an empty queue: exactly DEPTH reads, then release.
        flush = 1'b1; flush_addr = 32'h20; bus.instr_ready = 1'b0;
        tick();
        flush = 1'b0;
        check("flush_empty", 64'(bus.instr_valid), 64'd0);
        repeat (12) tick();
        check("bp_reads", 64'(issued), 64'(DEPTH));
        check("bp_rden_low", 64'(bus.im_rden), 64'd0);
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("bp_valid", 64'(bus.instr_valid), 64'd1);
            check("bp_pc", 64'(bus.pc), 64'(32'h20 + i));
            tick();
        end

        // HALT at address 5.
        halt_en = 1'b1; halt_addr = 32'h5;
        flush = 1'b1; flush_addr = '0;
        tick();
        flush = 1'b0;
        for (int t = 0; t < 60 && !bus.halted; t++) tick();
        check("halt_reached", 64'(bus.halted), 64'd1);
        check("halt_valid_low", 64'(bus.instr_valid), 64'd0);
        check("halt_pc", 64'(bus.pc), 64'h5);
        check("halt_delivered", 64'(popped), 64'd5);
        for (int t = 0; t < 20; t++) begin
            tick();
            check("halt_sticky", 64'(bus.halted), 64'd1);
        end

        // Flush clears halt; refill 3 entries plus one read in flight.
        flush = 1'b1; flush_addr = 32'h10; bus.instr_ready = 1'b0;
        tick();
        flush = 1'b0;
        check("flush_clears_halt", 64'(bus.halted), 64'd0);
        halt_en = 1'b0;
        repeat (5) tick();
        check("prefill_valid", 64'(bus.instr_valid), 64'd1);
        check("prefill_pc", 64'(bus.pc), 64'h10);

        // Flush together with a pop: flush wins.
        flush = 1'b1; flush_addr = 32'h40; bus.instr_ready = 1'b1;
        tick();
        flush = 1'b0;
        check("flushpop_valid", 64'(bus.instr_valid), 64'd0);
        check("flushpop_halted", 64'(bus.halted), 64'd0);
        tick();
        check("flush_rden", 64'(bus.im_rden), 64'd1);
        check("flush_rdaddr", 64'(bus.im_rdaddr), 64'h40);
        tick();
        check("flush_gap", 64'(bus.instr_valid), 64'd0);
        tick();
        check("flush_first_valid", 64'(bus.instr_valid), 64'd1);
        check("flush_first_pc", 64'(bus.pc), 64'h40);

        // Reset mid-stream with a read in flight.
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("midrst");
        tick();
        check("rst_rden", 64'(bus.im_rden), 64'd1);
        check("rst_rdaddr", 64'(bus.im_rdaddr), 64'd0);
        tick();
        check("rst_gap", 64'(bus.instr_valid), 64'd0);
        tick();
        check("rst_first_valid", 64'(bus.instr_valid), 64'd1);
        check("rst_first_pc", 64'(bus.pc), 64'd0);
        check("rst_first_instr", 64'(bus.instruction), 64'h100);

        // Address wrap.
        flush = 1'b1; flush_addr = 32'hFFFF_FFFE;
        tick();
        flush = 1'b0;
        repeat (2) tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("wrap_valid", 64'(bus.instr_valid), 64'd1);
            check("wrap_pc", 64'(bus.pc), 64'(wrap_pc[i]));
            check("wrap_instr", 64'(bus.instruction), 64'(wrap_instr[i]));
        end
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
